ultrasonido_ctrl: RTL and testbench
===================================

Name: ultrasonido_ctrl

Overview:
- Sequencer for an HC-SR04-style ultrasonic ranger.
- Fires a trigger pulse, measures echo high-time with a 2-FF synchronised echo, converts the width to centimetres without a divider, and reports one result per measurement.
- Supports single-shot (`start`) and free-running (`auto_en`) operation, with echo timeout and enforced repetition period.
- Sits between the sensor pins and the display/decision logic.

Parameters:
- TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
- CM_CYCLES, 2900, clk cycles of echo-high per centimetre (58 us at 50 MHz)
- MAX_CM, 400, saturation value of distance_cm
- WAIT_CYCLES, 1_500_000, max cycles from trigger end to echo rise (30 ms)
- PERIOD_CYCLES, 3_000_000, min cycles between successive trigger rising edges (60 ms)
- DW, 9, width of distance_cm

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request for one measurement
- auto_en  in  1  level; 1 = re-trigger every PERIOD_CYCLES
- echo  in  1  raw asynchronous echo from the sensor
- trig  out  1  trigger pulse to the sensor
- distance_cm  out  DW  last measured distance, held until the next result
- valid  out  1  1-cycle strobe when distance_cm/timeout update
- timeout  out  1  1 = last measurement had no echo, or echo exceeded MAX_CM
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; trig=0, distance_cm=0, valid=0, timeout=0, busy=0; all counters=0; synchroniser flops=0.
- echo passes through 2 flops (echo_s), then a third flop for rise/fall detection. Detection latency is 2-3 cycles; this is the same at both edges, so width is unaffected.
- IDLE:
  - start=1 or auto_en=1 -> TRIG next cycle.
  - Period counter clears on entry to TRIG.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO.
- WAIT_ECHO:
  - On echo_s rise -> MEASURE, with cm_cnt=0 and sub_cnt=0.
  - If WAIT_CYCLES elapse with no rise -> DONE with timeout=1.
- MEASURE, each cycle echo_s=1:
  - sub_cnt++.
  - When sub_cnt==CM_CYCLES-1: sub_cnt=0 and cm_cnt++.
  - If cm_cnt reaches MAX_CM -> DONE with timeout=1 and distance_cm=MAX_CM (saturate; do not wait for the fall).
  - On echo_s fall -> DONE with timeout=0 and distance_cm=cm_cnt (truncated; partial cm discarded).
- DONE (1 cycle):
  - valid=1; distance_cm and timeout registered.
  - Then HOLDOFF.
- HOLDOFF:
  - Waits until the period counter (running since TRIG entry) reaches PERIOD_CYCLES-1, then IDLE.
  - Guarantees a trigger-to-trigger spacing >= PERIOD_CYCLES.
- Start handling:
  - start outside IDLE is ignored (not queued).
  - start and auto_en together are treated as a single request.
- auto_en dropped mid-measurement: the current measurement completes; no new trigger follows.
- Echo already high on entry to WAIT_ECHO (stale echo): no rise is seen, so it is handled by the timeout path.
- Reset asserted mid-measurement: immediate return to reset values; trig drops asynchronously.
- busy is combinational from state; all other outputs are registered.

Optional Feature:
- Macro: ULTRASONIDO_AVG4_EN.
- Defined:
  - Non-timeout results shift into a 4-entry history.
  - distance_cm = (sum of the 4 entries) >> 2, using an 11-bit sum.
  - The history is zero after reset, so the first three outputs ramp up.
  - Timeout results do not enter the history; distance_cm holds its previous value and timeout=1.
  - valid timing is unchanged.
- Undefined: raw per-measurement value, as in Behaviour.

Decomposition:
- Package ultrasonido_pkg:
  - state enum {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF} (3 bits).
  - Default timing constants for 50 MHz.
  - Helper localparam for counter widths: clog2 of PERIOD_CYCLES and CM_CYCLES.
- Sub-module echo_sync: 2-FF synchroniser plus rise/fall pulse outputs, async active-low reset.

Test Plan:
Bench uses TRIG_CYCLES=5, CM_CYCLES=10, MAX_CM=20, WAIT_CYCLES=100, PERIOD_CYCLES=400.
- Single shot: start pulse; echo high 57 cycles after trig falls -> trig high exactly 5 cycles; valid once; distance_cm=5; timeout=0; busy low only after 400 cycles from trig rise.
- No echo: start, echo held 0 -> valid after 100 cycles in WAIT_ECHO; timeout=1; distance_cm=0.
- Saturation: echo held high for 300 cycles -> valid once cm_cnt hits 20 (about 200 cycles); distance_cm=20; timeout=1; no second valid at the echo fall.
- Free-running: auto_en=1 for 3 periods -> trig rising edges exactly 400 cycles apart; 3 valid strobes; clearing auto_en mid-MEASURE -> measurement finishes, then IDLE.
- Robustness: start during MEASURE -> ignored; reset=0 mid-MEASURE -> trig=0, busy=0, distance_cm=0 immediately.
- With ULTRASONIDO_AVG4_EN: echo widths giving 4, 8, 12, 16 cm -> distance_cm sequence 1, 3, 6, 10.

Source files
------------

// File: rtl/ultrasonido_pkg.sv
// Shared state encoding, 50 MHz timing defaults and counter-width helper
// for the ultrasonic ranger sequencer.
`default_nettype none

package ultrasonido_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    localparam int unsigned DEF_TRIG_CYCLES   = 500;
    localparam int unsigned DEF_CM_CYCLES     = 2900;
    localparam int unsigned DEF_MAX_CM        = 400;
    localparam int unsigned DEF_WAIT_CYCLES   = 1_500_000;
    localparam int unsigned DEF_PERIOD_CYCLES = 3_000_000;
    localparam int unsigned DEF_DW            = 9;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_PERIOD_W = cnt_w(DEF_PERIOD_CYCLES);
    localparam int unsigned DEF_CM_W     = cnt_w(DEF_CM_CYCLES);

endpackage

`default_nettype wire

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the raw echo pin, plus a third flop that
// yields single-cycle rise/fall pulses of the synchronised level.
`default_nettype none

module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo_i,
    output logic echo_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= echo_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign echo_s_o = sync2_q;
    assign rise_o   = sync2_q & ~prev_q;
    assign fall_o   = ~sync2_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/ultrasonido_ctrl.sv
// HC-SR04 sequencer: trigger, echo-width measurement in cm, timeout and
// repetition holdoff. ULTRASONIDO_AVG4_EN enables a 4-sample moving average.
`default_nettype none

module ultrasonido_ctrl
    import ultrasonido_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
    parameter int unsigned CM_CYCLES     = DEF_CM_CYCLES,
    parameter int unsigned MAX_CM        = DEF_MAX_CM,
    parameter int unsigned WAIT_CYCLES   = DEF_WAIT_CYCLES,
    parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int unsigned DW            = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          auto_en,
    input  logic          echo,
    output logic          trig,
    output logic [DW-1:0] distance_cm,
    output logic          valid,
    output logic          timeout,
    output logic          busy
);

    localparam int unsigned PW = cnt_w(PERIOD_CYCLES);
    localparam int unsigned CW = cnt_w(CM_CYCLES);
    localparam int unsigned SW = DW + 2;

    // The period counter doubles as trigger and echo-wait timer: it starts
    // at zero on TRIG entry, so both deadlines are absolute counts.
    localparam logic [PW-1:0] TRIG_END = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] WAIT_END = PW'(TRIG_CYCLES + WAIT_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_END = PW'(PERIOD_CYCLES - 2);
    localparam logic [PW-1:0] PER_MAX  = PW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] SUB_END  = CW'(CM_CYCLES - 1);
    localparam logic [DW-1:0] CM_LAST  = DW'(MAX_CM - 1);

    state_t        state_q;
    logic [PW-1:0] period_cnt_q;
    logic [CW-1:0] sub_cnt_q;
    logic [DW-1:0] cm_cnt_q;
    logic          trig_q;
    logic          valid_q;
    logic          timeout_q;
    logic [DW-1:0] distance_q;

    logic          echo_s;
    logic          echo_rise;
    logic          echo_fall;
    logic [DW-1:0] meas_dist_d;
    logic [DW-1:0] sat_dist_d;
    logic [DW-1:0] noecho_dist_d;

    echo_sync u_echo_sync (
        .clk      (clk),
        .reset    (reset),
        .echo_i   (echo),
        .echo_s_o (echo_s),
        .rise_o   (echo_rise),
        .fall_o   (echo_fall)
    );

`ifdef ULTRASONIDO_AVG4_EN
    logic [2:0][DW-1:0] hist_q;
    logic [SW-1:0]      sum_d;

    // The current measurement is the fourth entry; timeouts leave the output untouched.
    assign sum_d         = SW'(cm_cnt_q) + SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]);
    assign meas_dist_d   = DW'(sum_d >> 2);
    assign sat_dist_d    = distance_q;
    assign noecho_dist_d = distance_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else if (state_q == MEASURE && echo_fall) begin
            hist_q <= {hist_q[1:0], cm_cnt_q};
        end
    end
`else
    assign meas_dist_d   = cm_cnt_q;
    assign sat_dist_d    = DW'(MAX_CM);
    assign noecho_dist_d = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            sub_cnt_q    <= '0;
            cm_cnt_q     <= '0;
            trig_q       <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            distance_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            if (state_q != IDLE && period_cnt_q != PER_MAX) begin
                period_cnt_q <= period_cnt_q + PW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start || auto_en) begin
                        state_q      <= TRIG;
                        trig_q       <= 1'b1;
                        period_cnt_q <= '0;
                    end
                end
                TRIG: begin
                    if (period_cnt_q == TRIG_END) begin
                        state_q <= WAIT_ECHO;
                        trig_q  <= 1'b0;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_rise) begin
                        state_q   <= MEASURE;
                        cm_cnt_q  <= '0;
                        sub_cnt_q <= '0;
                    end else if (period_cnt_q == WAIT_END) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        timeout_q  <= 1'b1;
                        distance_q <= noecho_dist_d;
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        state_q    <= DONE;
                        valid_q    <= 1'b1;
                        timeout_q  <= 1'b0;
                        distance_q <= meas_dist_d;
                    end else if (echo_s) begin
                        if (sub_cnt_q == SUB_END) begin
                            sub_cnt_q <= '0;
                            cm_cnt_q  <= cm_cnt_q + DW'(1);
                            if (cm_cnt_q == CM_LAST) begin
                                state_q    <= DONE;
                                valid_q    <= 1'b1;
                                timeout_q  <= 1'b1;
                                distance_q <= sat_dist_d;
                            end
                        end else begin
                            sub_cnt_q <= sub_cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= HOLDOFF;
                end
                HOLDOFF: begin
                    // Leaving one cycle early puts the next TRIG exactly PERIOD_CYCLES after the last.
                    if (period_cnt_q >= HOLD_END) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig        = trig_q;
    assign distance_cm = distance_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ultrasonido_ctrl.sv
// Directed self-checking bench for ultrasonido_ctrl with shortened timing.
`default_nettype none

module tb_ultrasonido_ctrl;

    localparam int unsigned TRIG_CYCLES   = 5;
    localparam int unsigned CM_CYCLES     = 10;
    localparam int unsigned MAX_CM        = 20;
    localparam int unsigned WAIT_CYCLES   = 100;
    localparam int unsigned PERIOD_CYCLES = 400;
    localparam int unsigned DW            = 9;

`ifdef ULTRASONIDO_AVG4_EN
    int exp_ss       = 1;
    int exp_sat      = 0;
    int exp_free [3] = '{0, 1, 2};
    int exp_seq  [4] = '{1, 3, 6, 10};
`else
    int exp_ss       = 5;
    int exp_sat      = 20;
    int exp_free [3] = '{3, 3, 3};
    int exp_seq  [4] = '{4, 8, 12, 16};
`endif

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic          auto_en = 1'b0;
    logic          echo    = 1'b0;
    logic          trig;
    logic [DW-1:0] distance_cm;
    logic          valid;
    logic          timeout;
    logic          busy;

    int checks = 0;
    int fails  = 0;

    int            cyc           = 0;
    int            valid_total   = 0;
    int            trig_hi_total = 0;
    int            n_rise        = 0;
    int            rise_cyc [64];
    int            valid_cyc     = 0;
    logic [DW-1:0] last_dist     = '0;
    logic          last_to       = 1'b0;
    logic          trig_prev     = 1'b0;

    ultrasonido_ctrl #(
        .TRIG_CYCLES   (TRIG_CYCLES),
        .CM_CYCLES     (CM_CYCLES),
        .MAX_CM        (MAX_CM),
        .WAIT_CYCLES   (WAIT_CYCLES),
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .DW            (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .auto_en     (auto_en),
        .echo        (echo),
        .trig        (trig),
        .distance_cm (distance_cm),
        .valid       (valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (trig === 1'b1 && trig_prev !== 1'b1) begin
            if (n_rise < 64) rise_cyc[n_rise] = cyc;
            n_rise = n_rise + 1;
        end
        if (trig === 1'b1) trig_hi_total = trig_hi_total + 1;
        if (valid === 1'b1) begin
            valid_total = valid_total + 1;
            valid_cyc   = cyc;
            last_dist   = distance_cm;
            last_to     = timeout;
        end
        trig_prev = trig;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        echo    = 1'b0;
        start   = 1'b0;
        auto_en = 1'b0;
        reset   = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_trig_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (trig === 1'b1) break;
            tick(1);
        end
        for (int i = 0; i < 50; i++) begin
            if (trig === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++; if (trig !== 1'b0) begin fails++; $display("FAIL reset_trig: got %b expected 0", trig); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (distance_cm !== '0) begin fails++; $display("FAIL reset_distance: got %0d expected 0", distance_cm); end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_no_echo();
        bit ok;
        int r0;
        do_reset();
        r0 = n_rise;
        pulse_start();
        wait_valid(200, ok);
        checks++; if (!ok) begin fails++; $display("FAIL noecho_valid: got no valid expected valid"); end
        checks++; if (timeout !== 1'b1) begin fails++; $display("FAIL noecho_timeout: got %b expected 1", timeout); end
        checks++; if (distance_cm !== '0) begin fails++; $display("FAIL noecho_distance: got %0d expected 0", distance_cm); end
        checks++; if (cyc - rise_cyc[r0] != 105) begin fails++; $display("FAIL noecho_latency: got %0d expected 105", cyc - rise_cyc[r0]); end
        wait_idle(600, ok);
    endtask

    task automatic test_single_shot();
        bit ok;
        int r0, h0, v0;
        do_reset();
        r0 = n_rise; h0 = trig_hi_total; v0 = valid_total;
        pulse_start();
        wait_trig_fall(ok);
        checks++; if (!ok) begin fails++; $display("FAIL ss_trig: got no trigger expected trigger"); end
        echo = 1'b1;
        tick(57);
        echo = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok) begin fails++; $display("FAIL ss_valid: got no valid expected valid"); end
        checks++; if (distance_cm !== DW'(exp_ss)) begin fails++; $display("FAIL ss_distance: got %0d expected %0d", distance_cm, exp_ss); end
        checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL ss_timeout: got %b expected 0", timeout); end
        wait_idle(600, ok);
        checks++; if (!ok || cyc - rise_cyc[r0] != PERIOD_CYCLES - 1) begin
            fails++; $display("FAIL ss_busy_len: got %0d expected %0d", cyc - rise_cyc[r0], PERIOD_CYCLES - 1);
        end
        tick(5);
        checks++; if (trig_hi_total - h0 != TRIG_CYCLES) begin fails++; $display("FAIL ss_trig_width: got %0d expected %0d", trig_hi_total - h0, TRIG_CYCLES); end
        checks++; if (valid_total - v0 != 1) begin fails++; $display("FAIL ss_valid_count: got %0d expected 1", valid_total - v0); end
        checks++; if (n_rise - r0 != 1) begin fails++; $display("FAIL ss_trig_count: got %0d expected 1", n_rise - r0); end
    endtask

    task automatic test_saturation();
        bit ok;
        int v0, e0;
        do_reset();
        v0 = valid_total;
        pulse_start();
        wait_trig_fall(ok);
        checks++; if (!ok) begin fails++; $display("FAIL sat_trig: got no trigger expected trigger"); end
        echo = 1'b1;
        e0   = cyc;
        tick(300);
        echo = 1'b0;
        tick(20);
        checks++; if (valid_total - v0 != 1) begin fails++; $display("FAIL sat_valid_count: got %0d expected 1", valid_total - v0); end
        checks++; if (valid_cyc - e0 != 203) begin fails++; $display("FAIL sat_latency: got %0d expected 203", valid_cyc - e0); end
        checks++; if (last_dist !== DW'(exp_sat)) begin fails++; $display("FAIL sat_distance: got %0d expected %0d", last_dist, exp_sat); end
        checks++; if (last_to !== 1'b1) begin fails++; $display("FAIL sat_timeout: got %b expected 1", last_to); end
        wait_idle(600, ok);
    endtask

    task automatic test_free_running();
        bit ok;
        int r0, v0;
        do_reset();
        r0 = n_rise; v0 = valid_total;
        auto_en = 1'b1;
        for (int m = 0; m < 3; m++) begin
            wait_trig_fall(ok);
            checks++; if (!ok) begin fails++; $display("FAIL free_trig%0d: got no trigger expected trigger", m); end
            echo = 1'b1;
            if (m == 2) begin
                tick(15);
                auto_en = 1'b0;
                tick(20);
            end else begin
                tick(35);
            end
            echo = 1'b0;
            wait_valid(20, ok);
            checks++; if (!ok || distance_cm !== DW'(exp_free[m])) begin
                fails++; $display("FAIL free_distance%0d: got %0d expected %0d", m, distance_cm, exp_free[m]);
            end
        end
        wait_idle(600, ok);
        tick(450);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL free_stop_busy: got %b expected 0", busy); end
        checks++; if (n_rise - r0 != 3) begin fails++; $display("FAIL free_trig_count: got %0d expected 3", n_rise - r0); end
        checks++; if (valid_total - v0 != 3) begin fails++; $display("FAIL free_valid_count: got %0d expected 3", valid_total - v0); end
        checks++; if (rise_cyc[r0+1] - rise_cyc[r0] != PERIOD_CYCLES) begin
            fails++; $display("FAIL free_gap0: got %0d expected %0d", rise_cyc[r0+1] - rise_cyc[r0], PERIOD_CYCLES);
        end
        checks++; if (rise_cyc[r0+2] - rise_cyc[r0+1] != PERIOD_CYCLES) begin
            fails++; $display("FAIL free_gap1: got %0d expected %0d", rise_cyc[r0+2] - rise_cyc[r0+1], PERIOD_CYCLES);
        end
    endtask

    task automatic test_robustness();
        bit ok;
        int r0;
        do_reset();
        r0 = n_rise;
        pulse_start();
        wait_trig_fall(ok);
        echo = 1'b1;
        tick(20);
        pulse_start();
        tick(36);
        echo = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok || distance_cm !== DW'(exp_ss)) begin fails++; $display("FAIL rob_distance: got %0d expected %0d", distance_cm, exp_ss); end
        wait_idle(600, ok);
        tick(100);
        checks++; if (n_rise - r0 != 1) begin fails++; $display("FAIL rob_start_ignored: got %0d triggers expected 1", n_rise - r0); end

        pulse_start();
        wait_trig_fall(ok);
        echo = 1'b1;
        tick(20);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rob_busy_pre: got %b expected 1", busy); end
        #3 reset = 1'b0;
        #1;
        checks++; if (trig !== 1'b0) begin fails++; $display("FAIL rob_rst_trig: got %b expected 0", trig); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rob_rst_busy: got %b expected 0", busy); end
        checks++; if (distance_cm !== '0) begin fails++; $display("FAIL rob_rst_distance: got %0d expected 0", distance_cm); end
        echo = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);

        pulse_start();
        tick(2);
        checks++; if (trig !== 1'b1) begin fails++; $display("FAIL rob_trig_high: got %b expected 1", trig); end
        #3 reset = 1'b0;
        #1;
        checks++; if (trig !== 1'b0) begin fails++; $display("FAIL rob_trig_async: got %b expected 0", trig); end
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_sequence();
        bit ok;
        int widths [4] = '{45, 85, 125, 165};
        do_reset();
        for (int m = 0; m < 4; m++) begin
            pulse_start();
            wait_trig_fall(ok);
            echo = 1'b1;
            tick(widths[m]);
            echo = 1'b0;
            wait_valid(20, ok);
            checks++; if (!ok || distance_cm !== DW'(exp_seq[m]) || timeout !== 1'b0) begin
                fails++; $display("FAIL seq_distance%0d: got %0d/to=%b expected %0d/to=0", m, distance_cm, timeout, exp_seq[m]);
            end
            wait_idle(600, ok);
        end
    endtask

    initial begin
        test_reset();
        test_no_echo();
        test_single_shot();
        test_saturation();
        test_free_running();
        test_robustness();
        test_sequence();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
